// File: rtl/iter_shifter_if.sv
// iter_shifter_if -- request/result bundle for the iterative shifter.
//   start  : request strobe (sampled in IDLE/DONE only)
//   op     : 00 LSR, 01 LSL, 10 ASR, 11 ROR (LSR unless SHIFTER_ROTATE_EN)
//   shamt  : shift amount, 0..WIDTH-1
//   d_in   : operand
//   d_out  : data register (intermediate during SHIFT, result from DONE on)
//   busy   : high while shifting
//   done   : one-cycle completion flag
// master = requester side, slave = shifter side.
interface iter_shifter_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             start;
  logic [1:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             busy;
  logic             done;

  modport master (output start, op, shamt, d_in, input d_out, busy, done);
  modport slave  (input start, op, shamt, d_in, output d_out, busy, done);
endinterface

// File: rtl/iter_shifter.sv
// iter_shifter -- one-bit-per-cycle shifter (LSR/LSL/ASR, optional ROR).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : iter_shifter_if.slave (start/op/shamt/d_in in, d_out/busy/done out)
// Build option: define SHIFTER_ROTATE_EN to make op=11 rotate right;
// otherwise op=11 is a plain logical shift right and no rotate path exists.
// A request with shamt=N reaches DONE N+1 edges after the accepting edge
// counts as the first; DONE accepts a new start directly (no dead cycle).
module iter_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  iter_shifter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic [1:0]       mode_q,  mode_d;

  // Single-bit step for the latched mode.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                            input logic [1:0] m);
    logic [WIDTH-1:0] r;
    r = {1'b0, d[WIDTH-1:1]};
    case (m)
      2'b01:   r = {d[WIDTH-2:0], 1'b0};
      2'b10:   r = {d[WIDTH-1], d[WIDTH-1:1]};
`ifdef SHIFTER_ROTATE_EN
      2'b11:   r = {d[0], d[WIDTH-1:1]};
`endif
      default: r = {1'b0, d[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.start) begin
          data_d  = bus.d_in;
          cnt_d   = bus.shamt;
          mode_d  = bus.op;
          state_d = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // Inputs are deliberately not looked at here.
        data_d = step(data_q, mode_q);
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.d_out = data_q;
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter: WIDTH, 8, data width in bits; SHALL be a power of two, at least 4.
REQ-002 Parameter: SHW, 3, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request; accepted only in IDLE or DONE.
REQ-006 Port: op  input  2  mode: 00 LSR, 01 LSL, 10 ASR, 11 ROR (macro-dependent, REQ-021/022).
REQ-007 Port: shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-008 Port: d_in  input  WIDTH  operand.
REQ-009 Port: d_out  output  WIDTH  data register contents; final result valid from DONE until the next accepted start.
REQ-010 Port: busy  output  1  high exactly while the FSM is in SHIFT.
REQ-011 Port: done  output  1  high for exactly one cycle, while the FSM is in DONE.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE; transitions occur only on rising clk.
REQ-013 Accepted start SHALL latch d_in into the data register, shamt into a down-counter and op into a mode register; next state SHIFT if shamt != 0, else DONE.
REQ-014 In SHIFT, each cycle SHALL shift the data register by one bit per the latched op and decrement the counter; at the edge where the counter goes 1 -> 0, next state SHALL be DONE.
REQ-015 One-bit steps: LSR inserts 0 at MSB; LSL inserts 0 at LSB; ASR replicates the old MSB; ROR moves the old LSB to the MSB.
REQ-016 Latency: DONE SHALL be entered on the (shamt+1)th rising edge, counting the start-sampling edge as the first (shamt=0 -> 1 edge; shamt=WIDTH-1 -> WIDTH edges).
REQ-017 DONE SHALL go to IDLE on the next edge unless start is high, in which case it is accepted as in IDLE (back-to-back, no dead cycle).
REQ-018 start, op, shamt and d_in SHALL be ignored while in SHIFT; the latched operation SHALL be unaffected.
REQ-019 d_out SHALL show intermediate values during SHIFT and hold the final result unchanged in IDLE until the next accepted start.

Reset
REQ-020 Reset asserted SHALL immediately force state IDLE, data register 0 (d_out = 0), counter 0, mode 00, busy 0 and done 0, including mid-SHIFT; the interrupted operation is discarded and the first edge after deassertion with start high SHALL be accepted normally.

Configuration
REQ-021 With SHIFTER_ROTATE_EN defined, op=11 SHALL perform rotate-right per REQ-015.
REQ-022 Without SHIFTER_ROTATE_EN, op=11 SHALL behave exactly as LSR (00) with identical latency, and no rotate logic shall be present.

Verification (WIDTH=8)
REQ-023 LSR d_in=8'hB4, shamt=3 -> done on 4th edge, d_out=8'h16; busy high for exactly 3 cycles.
REQ-024 ASR d_in=8'hB4, shamt=2 -> d_out=8'hED; LSL d_in=8'h81, shamt=7 -> d_out=8'h80 with done on 8th edge.
REQ-025 op=11, d_in=8'h81, shamt=1 -> d_out=8'hC0 with SHIFTER_ROTATE_EN, 8'h40 without.
REQ-026 shamt=0, d_in=8'h5A -> busy never high, done on 1st edge, d_out=8'h5A; start held high in DONE -> next op accepted with no idle cycle.
REQ-027 Start LSR 8'hFF shamt=7; pulse start with d_in=8'h00 after 2 edges -> ignored, result 8'h01; reassert reset mid-SHIFT -> d_out=0, busy=0, done=0 immediately (asynchronous), FSM in IDLE.
